// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with zero-latency lookup, an update port and saturating statistics.
// Lookup is combinational; updates and statistics commit on the clk edge; there is no backpressure and every update is accepted.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_if,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  input  logic [31:0]      upd_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic              validQ  [ENTRIES];
  logic [TAG_W-1:0]  tagQ    [ENTRIES];
  logic [1:0]        ctrQ    [ENTRIES];
  logic [31:0]       targetQ [ENTRIES];

  logic [IDX_W-1:0]  lkIdx;
  logic [TAG_W-1:0]  lkTag;
  logic [IDX_W-1:0]  updIdx;
  logic [TAG_W-1:0]  updTag;
  logic              updHit;
  logic              unusedPcBits;

  // Word-aligned PCs: the byte offset never reaches the table.
  assign unusedPcBits = ^{pc_if[1:0], upd_pc[1:0]};

  assign lkIdx  = pc_if[IDX_W+1:2];
  assign lkTag  = pc_if[31:IDX_W+2];
  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[31:IDX_W+2];

  assign pred_hit    = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
  assign pred_taken  = pred_hit && ctrQ[lkIdx][1];
  assign pred_target = pred_taken ? targetQ[lkIdx] : pc_if + 32'd4;

  assign updHit     = validQ[updIdx] && (tagQ[updIdx] == updTag);
  assign mispredict = upd_en && (upd_pred != upd_taken);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        ctrQ[i]    <= 2'b01;
        targetQ[i] <= '0;
      end
    end else if (upd_en) begin
      if (updHit) begin
        if (upd_taken) begin
          ctrQ[updIdx]    <= (ctrQ[updIdx] == 2'b11) ? 2'b11 : ctrQ[updIdx] + 2'd1;
          targetQ[updIdx] <= upd_target;
        end else begin
          ctrQ[updIdx] <= (ctrQ[updIdx] == 2'b00) ? 2'b00 : ctrQ[updIdx] - 2'd1;
        end
      end else begin
        // Miss replaces whatever aliased into this slot, starting in a weak state.
        validQ[updIdx]  <= 1'b1;
        tagQ[updIdx]    <= updTag;
        ctrQ[updIdx]    <= upd_taken ? 2'b10 : 2'b01;
        targetQ[updIdx] <= upd_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (upd_en) begin
      if (!(&branch_cnt)) branch_cnt <= branch_cnt + 1'b1;
      if (mispredict && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the driver pushes expected outputs from a behavioural model,
// the monitor pops and compares them mid-cycle.
module tb_branch_predictor;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   pc_if = '0;
  logic          pred_hit, pred_taken;
  logic [31:0]   pred_target;
  logic          upd_en = 1'b0;
  logic [31:0]   upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic          upd_pred = 1'b0;
  logic [31:0]   upd_target = '0;
  logic          mispredict;
  logic [CW-1:0] branch_cnt, miss_cnt;

  branch_predictor #(.IDX_W(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pc_if(pc_if),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .upd_target(upd_target), .mispredict(mispredict),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    bit          taken;
    bit [31:0]   target;
    bit          misp;
    int          bcnt;
    int          mcnt;
  } exp_t;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nFailed   = 0;

  // Behavioural reference: a 16-slot table keyed by word address, counters as plain ints.
  bit        mValid [16];
  int unsigned mTag [16];
  int        mCtr   [16];
  bit [31:0] mTgt   [16];
  int        mBranch, mMiss;

  function automatic int slotOf(bit [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int unsigned tagOf(bit [31:0] pc);
    return int'(pc / 64);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mTag[i] = 0; mCtr[i] = 1; mTgt[i] = 0;
    end
    mBranch = 0; mMiss = 0;
  endtask

  task automatic check(string name, int unsigned act, int unsigned req);
    nCompared++;
    if (act !== req) begin
      nFailed++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
    end
  endtask

  // One cycle of stimulus: drive at negedge, predict, then advance the model past the coming edge.
  task automatic step(bit [31:0] pc, bit en, bit [31:0] upc, bit tk, bit pr, bit [31:0] tgt, bit rst);
    exp_t e;
    int   s;
    bit   hitU, mispNow;
    @(negedge clk);
    pc_if = pc; upd_en = en; upd_pc = upc; upd_taken = tk; upd_pred = pr; upd_target = tgt;
    reset = rst;
    if (rst) modelReset();
    #1;
    s = slotOf(pc);
    e.hit    = mValid[s] && (mTag[s] == tagOf(pc));
    e.taken  = e.hit && (mCtr[s] >= 2);
    e.target = e.taken ? mTgt[s] : pc + 32'd4;
    mispNow  = en && (pr != tk);
    e.misp   = mispNow;
    e.bcnt   = mBranch;
    e.mcnt   = mMiss;
    expQ.push_back(e);
    if (en && !rst) begin
      s = slotOf(upc);
      hitU = mValid[s] && (mTag[s] == tagOf(upc));
      if (hitU) begin
        if (tk) begin
          mCtr[s] = (mCtr[s] + 1 > 3) ? 3 : mCtr[s] + 1;
          mTgt[s] = tgt;
        end else begin
          mCtr[s] = (mCtr[s] - 1 < 0) ? 0 : mCtr[s] - 1;
        end
      end else begin
        mValid[s] = 1; mTag[s] = tagOf(upc); mCtr[s] = tk ? 2 : 1; mTgt[s] = tgt;
      end
      mBranch = (mBranch + 1 > 15) ? 15 : mBranch + 1;
      if (mispNow) mMiss = (mMiss + 1 > 15) ? 15 : mMiss + 1;
    end
  endtask

  task automatic look(bit [31:0] pc);
    step(pc, 0, $urandom, 1'($urandom), 1'($urandom), $urandom, 0);
  endtask

  task automatic upd(bit [31:0] pc, bit [31:0] upc, bit tk, bit pr, bit [31:0] tgt);
    step(pc, 1, upc, tk, pr, tgt, 0);
  endtask

  // Monitor: every cycle the DUT presents a lookup result; compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("pred_hit",    32'(pred_hit),    32'(e.hit));
        check("pred_taken",  32'(pred_taken),  32'(e.taken));
        check("pred_target", pred_target,      e.target);
        check("mispredict",  32'(mispredict),  32'(e.misp));
        check("branch_cnt",  32'(branch_cnt),  32'(e.bcnt));
        check("miss_cnt",    32'(miss_cnt),    32'(e.mcnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bit [31:0] randPc();
    bit [31:0] bases [3];
    bases[0] = 32'h0040_0000; bases[1] = 32'h0040_0040; bases[2] = 32'h8000_1000;
    return bases[$urandom_range(2)] | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
  endfunction

  initial begin
    modelReset();
    step(32'h0040_0010, 0, 0, 0, 0, 0, 1);
    look(32'h0040_0010);
    upd(32'h0040_0010, 32'h0040_0010, 1, 0, 32'h0040_0100);
    look(32'h0040_0010);
    repeat (3) upd(32'h0040_0010, 32'h0040_0010, 1, 1, 32'h0040_0100);
    look(32'h0040_0010);
    repeat (2) upd(32'h0040_0010, 32'h0040_0010, 0, 1, 32'h0);
    look(32'h0040_0010);
    repeat (4) upd(32'h0040_0010, 32'h0040_0010, 0, 0, 32'h0);
    look(32'h0040_0010);
    upd(32'h0040_0010, 32'h0040_0050, 0, 0, 32'h0040_0200);
    look(32'h0040_0010);
    look(32'h0040_0050);
    upd(32'h0040_0020, 32'h0040_0020, 1, 0, 32'h0040_0300);
    look(32'h0040_0020);
    // Reset asserted between edges while an update is being presented.
    step(32'h0040_0020, 1, 32'h0040_0020, 1, 0, 32'h0040_0400, 1);
    look(32'h0040_0020);
    for (int i = 0; i < 20; i++) begin
      bit tk;
      tk = 1'($urandom);
      upd(randPc(), randPc(), tk, !tk, $urandom);
    end
    look(32'hFFFF_FFFC);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0)
        step(randPc(), 1'($urandom), randPc(), 1'($urandom), 1'($urandom), $urandom, 1);
      else
        step(randPc(), 1'($urandom), randPc(), 1'($urandom), 1'($urandom), $urandom, 0);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Branch prediction unit that consumes the ID-stage branch resolution (the equality-compare result, converted to taken/not-taken by the control path).
- Supplies a taken/not-taken guess and a target address to the IF stage.
- Direct-mapped table of 2-bit saturating counters with tag and target per entry, plus saturating branch/mispredict statistics counters.
- Sits between PC-select logic in IF and branch resolution in ID.

Parameters:
- IDX_W, 4, index width; table holds 2**IDX_W entries.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_if  input  32  PC of the instruction being fetched.
- pred_hit  output  1  table entry valid and tag matches pc_if.
- pred_taken  output  1  predicted taken.
- pred_target  output  32  next-PC guess.
- upd_en  input  1  branch resolved in ID this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual outcome.
- upd_pred  input  1  prediction that was used for this branch (carried down the pipe).
- upd_target  input  32  computed branch target.
- mispredict  output  1  upd_en and (upd_pred != upd_taken); combinational.
- branch_cnt  output  CNT_W  resolved branches, saturating.
- miss_cnt  output  CNT_W  mispredicts, saturating.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - pc[1:0] is ignored.
- Per entry: valid (1 bit), tag, ctr (2 bits), target (32 bits).
- Lookup is combinational, zero latency:
  - pred_hit = valid[idx] & (tag[idx] == tag(pc_if)).
  - pred_taken = pred_hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : pc_if + 4 (32-bit wrap; 0xFFFFFFFC gives 0x00000000).
- Update on the rising clk edge when upd_en = 1, entry at idx(upd_pc):
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch): allocate with valid = 1, tag = tag(upd_pc), ctr = upd_taken ? 2'b10 : 2'b01, target = upd_target. The old entry is replaced.
- Counter states:
  - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Predict taken when ctr[1] = 1.
- Statistics on each upd_en clock edge:
  - branch_cnt increments, saturating at all-ones.
  - miss_cnt increments when mispredict = 1, saturating at all-ones.
- Simultaneous lookup and update to the same idx: the lookup returns the pre-update state. No bypass; the new state is visible the next cycle.
- upd_en = 0: no state changes; upd_* values are don't-care.
- Reset, asynchronous, effective immediately and also mid-update:
  - all valid = 0, all ctr = 01, all target = 0, all tags = 0.
  - branch_cnt = 0, miss_cnt = 0.
  - Consequent outputs during and after reset: pred_hit = 0, pred_taken = 0, pred_target = pc_if + 4, mispredict follows its inputs.
- The table is register-based, with no RAM inference requirement.

Test Plan:
- Reset, then pc_if = 0x00400010 -> pred_hit 0, pred_taken 0, pred_target 0x00400014, branch_cnt 0, miss_cnt 0.
- Update upd_pc = 0x00400010, taken = 1, pred = 0, target = 0x00400100 -> mispredict 1 in that cycle. Next cycle with pc_if = 0x00400010: pred_hit 1, pred_taken 1, pred_target 0x00400100, branch_cnt 1, miss_cnt 1.
- Counter saturation:
  - Three more taken updates on 0x00400010 -> ctr = 11.
  - Then two not-taken updates -> ctr = 01, pred_taken 0, pred_target 0x00400014.
  - Four further not-taken updates -> ctr stays 00.
- Alias eviction: entry for 0x00400010 exists; update 0x00400050 (same idx 4, different tag) not-taken -> lookup of 0x00400010 gives pred_hit 0; lookup of 0x00400050 gives hit with ctr 01.
- Same-cycle lookup and update on the same PC, from invalid -> pred_hit 0 in that cycle, 1 the next cycle. Assert reset mid-sequence -> all outputs return to reset values asynchronously, before the next clk edge.
- Statistics saturation with CNT_W = 4: 20 mispredicted updates -> branch_cnt = miss_cnt = 15; pc_if = 0xFFFFFFFC on a miss -> pred_target 0x00000000.
